// File: rtl/vga_pkg.sv
// Shared screen enum and per-screen background colours for the display path.
// Also holds the 4:4:4 colour stepping helper used by the optional fade.
package vga_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    GAME  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } screen_t;

  localparam logic [11:0] MENU_BG_COLOR  = 12'h000;
  localparam logic [11:0] GAME_BG_COLOR  = 12'hF80;
  localparam logic [11:0] PAUSE_BG_COLOR = 12'h226;
  localparam logic [11:0] OVER_BG_COLOR  = 12'hF00;

  function automatic logic [11:0] color_of(input screen_t s);
    logic [11:0] c;
    c = MENU_BG_COLOR;
    unique case (s)
      MENU:  c = MENU_BG_COLOR;
      GAME:  c = GAME_BG_COLOR;
      PAUSE: c = PAUSE_BG_COLOR;
      OVER:  c = OVER_BG_COLOR;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] chan_step(
    input logic [3:0] cur,
    input logic [3:0] tgt
  );
    logic [3:0] r;
    r = cur;
    if (cur < tgt)
      r = cur + 4'd1;
    else if (cur > tgt)
      r = cur - 4'd1;
    return r;
  endfunction

  function automatic logic [11:0] fade_step(
    input logic [11:0] cur,
    input logic [11:0] tgt
  );
    return {chan_step(cur[11:8], tgt[11:8]),
            chan_step(cur[7:4],  tgt[7:4]),
            chan_step(cur[3:0],  tgt[3:0])};
  endfunction

endpackage

// File: rtl/frame_boundary_det.sv
// Detects the vblnk rising edge and emits a registered 1-cycle frame_tick.
// armed_q blocks a false edge when vblnk is already high at reset release.
module frame_boundary_det (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic boundary,
  output logic frame_tick
);

  logic vblnk_q, vblnk_d;
  logic armed_q, armed_d;
  logic tick_q, tick_d;

  always_comb begin
    boundary = vblnk & ~vblnk_q & armed_q;
    vblnk_d  = vblnk;
    armed_d  = armed_q | ~vblnk;
    tick_d   = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      armed_q <= ~vblnk;
      tick_q  <= 1'b0;
    end else begin
      vblnk_q <= vblnk_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// Screen-state scheduler: latches events, switches screen only at vblnk rise.
// Define SCREEN_FADE_EN to step bg_color toward the target instead of jumping.
module game_screen_ctrl
  import vga_pkg::*;
#(
  parameter int OVER_HOLD_FRAMES = 180,
  parameter int FADE_STEP_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        game_over,
  output logic [1:0]  screen,
  output logic [11:0] bg_color,
  output logic        game_active,
  output logic        frame_tick
);

  localparam logic [15:0] HOLD_LAST = 16'(OVER_HOLD_FRAMES - 1);

  logic        boundary;
  logic        start_q, start_d;
  logic        pause_q, pause_d;
  logic        start_pend_q, start_pend_d;
  logic        pause_pend_q, pause_pend_d;
  logic        over_pend_q, over_pend_d;
  screen_t     screen_q, screen_d;
  logic [11:0] bg_q, bg_d;
  logic        active_q, active_d;
  logic [15:0] hold_q, hold_d;

  logic        start_ev, pause_ev, over_ev;
  logic        expired;
  screen_t     next_scr;
  logic [11:0] target;

`ifdef SCREEN_FADE_EN
  localparam logic [3:0] STEP_LAST = 4'(FADE_STEP_FRAMES - 1);
  logic [3:0] fade_cnt_q, fade_cnt_d;
`endif

  frame_boundary_det u_fbd (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .boundary   (boundary),
    .frame_tick (frame_tick)
  );

  // Events arriving on the boundary cycle itself count for that boundary
  always_comb begin
    start_d  = start_btn;
    pause_d  = pause_btn;
    start_ev = start_pend_q | (start_btn & ~start_q);
    pause_ev = pause_pend_q | (pause_btn & ~pause_q);
    over_ev  = over_pend_q | game_over;
    expired  = hold_q == HOLD_LAST;

    next_scr = screen_q;
    unique case (screen_q)
      MENU:
        if (start_ev) next_scr = GAME;
      GAME:
        if (over_ev)
          next_scr = OVER;
        else if (pause_ev)
          next_scr = PAUSE;
      PAUSE:
        if (pause_ev || start_ev) next_scr = GAME;
      OVER:
        if (start_ev || expired) next_scr = MENU;
    endcase
    target = color_of(next_scr);

    screen_d     = screen_q;
    active_d     = active_q;
    hold_d       = hold_q;
    start_pend_d = start_ev;
    pause_pend_d = pause_ev;
    over_pend_d  = over_ev;

    if (boundary) begin
      screen_d     = next_scr;
      active_d     = next_scr == GAME;
      start_pend_d = 1'b0;
      pause_pend_d = 1'b0;
      over_pend_d  = 1'b0;
      if (screen_q == OVER && next_scr == OVER)
        hold_d = hold_q + 16'd1;
      else
        hold_d = 16'd0;
    end

`ifdef SCREEN_FADE_EN
    fade_cnt_d = fade_cnt_q;
    bg_d       = bg_q;
    if (boundary) begin
      if (fade_cnt_q >= STEP_LAST) begin
        fade_cnt_d = 4'd0;
        bg_d       = fade_step(bg_q, target);
      end else begin
        fade_cnt_d = fade_cnt_q + 4'd1;
      end
    end
`else
    bg_d = boundary ? target : bg_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      start_pend_q <= 1'b0;
      pause_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
      screen_q     <= MENU;
      bg_q         <= MENU_BG_COLOR;
      active_q     <= 1'b0;
      hold_q       <= 16'd0;
`ifdef SCREEN_FADE_EN
      fade_cnt_q   <= 4'd0;
`endif
    end else begin
      start_q      <= start_d;
      pause_q      <= pause_d;
      start_pend_q <= start_pend_d;
      pause_pend_q <= pause_pend_d;
      over_pend_q  <= over_pend_d;
      screen_q     <= screen_d;
      bg_q         <= bg_d;
      active_q     <= active_d;
      hold_q       <= hold_d;
`ifdef SCREEN_FADE_EN
      fade_cnt_q   <= fade_cnt_d;
`endif
    end
  end

  assign screen      = screen_q;
  assign bg_color    = bg_q;
  assign game_active = active_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Scoreboard bench for game_screen_ctrl: stimulus queues expected frame state,
// a monitor pops and compares on every frame_tick.
module tb_game_screen_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        start_btn;
  logic        pause_btn;
  logic        game_over;
  logic [1:0]  screen;
  logic [11:0] bg_color;
  logic        game_active;
  logic        frame_tick;

  typedef struct packed {
    logic [1:0]  scr;
    logic [11:0] bg;
    logic        ga;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_MENU  = 2'd0;
  localparam logic [1:0] S_GAME  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  always #5 clk = ~clk;

  game_screen_ctrl #(
    .OVER_HOLD_FRAMES (3),
    .FADE_STEP_FRAMES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .game_over   (game_over),
    .screen      (screen),
    .bg_color    (bg_color),
    .game_active (game_active),
    .frame_tick  (frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] bg_of(input logic [1:0] s);
    logic [11:0] c;
    case (s)
      S_MENU:  c = 12'h000;
      S_GAME:  c = 12'hF80;
      S_PAUSE: c = 12'h226;
      default: c = 12'hF00;
    endcase
    return c;
  endfunction

  function automatic exp_t mk(input logic [1:0] s, input logic [11:0] bg);
    exp_t e;
    e.scr = s;
    e.bg  = bg;
    e.ga  = (s == S_GAME);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && frame_tick) begin
      if (q.size() == 0) begin
        chk("unexpected_tick", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_screen", 32'(screen), 32'(e.scr));
        chk("tick_bg", 32'(bg_color), 32'(e.bg));
        chk("tick_game_active", 32'(game_active), 32'(e.ga));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_exp(input exp_t e);
    q.push_back(e);
    vblnk = 1'b1;
    cyc();
    cyc();
    vblnk = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic frame_s(input logic [1:0] s);
    frame_exp(mk(s, bg_of(s)));
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    cyc();
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    cyc();
    pause_btn = 1'b0;
    cyc();
  endtask

  task automatic pulse_over();
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    cyc();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_screen"}, 32'(screen), 32'(S_MENU));
    chk({tag, "_bg"}, 32'(bg_color), 32'h000);
    chk({tag, "_game_active"}, 32'(game_active), 32'd0);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    vblnk     = 1'b1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    game_over = 1'b0;
    repeat (3) cyc();
    check_reset_state("reset");

    // vblnk stays high through release: no boundary may appear
    rst = 1'b0;
    repeat (4) cyc();
    chk("no_tick_after_release", 32'(frame_tick), 32'd0);
    vblnk = 1'b0;
    repeat (4) cyc();

`ifdef SCREEN_FADE_EN
    begin
      logic [11:0] ramp [15];
      ramp = '{12'h110, 12'h220, 12'h330, 12'h440, 12'h550,
               12'h660, 12'h770, 12'h880, 12'h980, 12'hA80,
               12'hB80, 12'hC80, 12'hD80, 12'hE80, 12'hF80};
      press_start();
      for (int k = 0; k < 15; k++)
        frame_exp(mk(S_GAME, ramp[k]));
      frame_exp(mk(S_GAME, 12'hF80));
      press_pause();
      frame_exp(mk(S_PAUSE, 12'hE71));
      frame_exp(mk(S_PAUSE, 12'hD62));
      rst = 1'b1;
      cyc();
      check_reset_state("mid_fade_rst");
      rst = 1'b0;
      repeat (3) cyc();
    end
`else
    press_start();
    chk("menu_until_boundary", 32'(screen), 32'(S_MENU));
    frame_s(S_GAME);

    press_start();
    frame_s(S_GAME);

    // game_over beats pause; pause must not leak into the next frame
    press_pause();
    pulse_over();
    frame_s(S_OVER);
    frame_s(S_OVER);
    frame_s(S_OVER);
    frame_s(S_MENU);

    press_start();
    frame_s(S_GAME);
    press_pause();
    frame_s(S_PAUSE);

    press_pause();
    press_pause();
    press_pause();
    frame_s(S_GAME);
    frame_s(S_GAME);

    press_pause();
    frame_s(S_PAUSE);
    pulse_over();
    frame_s(S_PAUSE);
    press_start();
    frame_s(S_GAME);

    // game_over on the boundary cycle itself
    q.push_back(mk(S_OVER, bg_of(S_OVER)));
    vblnk     = 1'b1;
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    cyc();
    vblnk = 1'b0;
    repeat (6) cyc();
    frame_s(S_OVER);
    press_start();
    frame_s(S_MENU);

    // reset mid-frame discards a pending start
    press_start();
    rst = 1'b1;
    cyc();
    check_reset_state("mid_frame_rst");
    rst = 1'b0;
    repeat (3) cyc();
    frame_s(S_MENU);
`endif

    repeat (10) cyc();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
